// File: rtl/fetch_prefetch_if.sv
// Decoder/PMEM-facing signal bundle of the prefetching fetch stage.
// master = decoder + program memory side, slave = fetch_prefetch.
interface fetch_prefetch_if #(
  parameter int PC_WIDTH   = 12,
  parameter int PMEM_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH + 1)
);
  logic [PC_WIDTH-1:0]   in_branch_pc;
  logic                  in_set_pc;
  logic                  in_flush;
  logic                  in_stall;
  logic [PMEM_WIDTH-1:0] in_instr;
  logic [PC_WIDTH-1:0]   out_pmem_addr;
  logic [PMEM_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]   out_pc;
  logic                  out_valid;
  logic [LVL_WIDTH-1:0]  out_fill_level;

  modport master (
    output in_branch_pc, in_set_pc, in_flush, in_stall, in_instr,
    input  out_pmem_addr, out_instr, out_pc, out_valid, out_fill_level
  );

  modport slave (
    input  in_branch_pc, in_set_pc, in_flush, in_stall, in_instr,
    output out_pmem_addr, out_instr, out_pc, out_valid, out_fill_level
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage: FIFO_DEPTH-entry instr/PC queue plus one in-flight PMEM read.
// Define FETCH_BYPASS_EN to present an arriving word combinationally when the queue is empty.
module fetch_prefetch #(
  parameter int PC_WIDTH     = 12,
  parameter int PMEM_WIDTH   = 16,
  parameter int PC_INCREMENT = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int RESET_PC     = 0,
  parameter int LVL_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
  input logic             clock,
  input logic             reset,
  fetch_prefetch_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0]  PC_INC    = PC_WIDTH'(PC_INCREMENT);
  localparam logic [PC_WIDTH-1:0]  PC_RST    = PC_WIDTH'(RESET_PC);
  localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
  localparam logic [LVL_WIDTH-1:0] LVL_ONE   = LVL_WIDTH'(1);
  localparam logic [LVL_WIDTH:0]   DEPTH_EXT = (LVL_WIDTH + 1)'(FIFO_DEPTH);

  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  infl_valid_q, infl_valid_d;
  logic [PC_WIDTH-1:0]   infl_pc_q, infl_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_WIDTH-1:0]  count_q, count_d;
  logic [PMEM_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem    [FIFO_DEPTH];

  logic                  queue_valid, bypass_valid, head_valid;
  logic [PMEM_WIDTH-1:0] head_instr;
  logic [PC_WIDTH-1:0]   head_pc;
  logic                  pop, queue_pop, push, mem_we, has_room, issue;
  logic [LVL_WIDTH:0]    occupancy;

  assign queue_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_valid = !queue_valid && infl_valid_q;
`else
  assign bypass_valid = 1'b0;
`endif

  assign head_valid = queue_valid || bypass_valid;
  assign head_instr = queue_valid  ? instr_mem[rd_ptr_q] :
                      bypass_valid ? bus.in_instr        : '0;
  assign head_pc    = queue_valid  ? pc_mem[rd_ptr_q]    :
                      bypass_valid ? infl_pc_q           : '0;

  assign pop       = head_valid && !bus.in_stall;
  assign queue_pop = pop && queue_valid;
  // A bypassed word that the decoder takes this cycle never enters the queue.
  assign push      = infl_valid_q && !(bypass_valid && pop);
  assign mem_we    = push && !bus.in_set_pc && !bus.in_flush;

  // Counting the in-flight word as occupied guarantees its slot exists when it lands.
  assign occupancy = {1'b0, count_q} + {{LVL_WIDTH{1'b0}}, infl_valid_q};
  assign has_room  = (occupancy < DEPTH_EXT);
  assign issue     = !bus.in_flush && (has_room || pop);

  assign bus.out_pmem_addr  = bus.in_set_pc ? bus.in_branch_pc : fetch_pc_q;
  assign bus.out_valid      = head_valid;
  assign bus.out_instr      = head_instr;
  assign bus.out_pc         = head_pc;
  assign bus.out_fill_level = count_q;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    fetch_pc_d   = fetch_pc_q;
    infl_valid_d = infl_valid_q;
    infl_pc_d    = infl_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (bus.in_set_pc) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      infl_valid_d = 1'b1;
      infl_pc_d    = bus.in_branch_pc;
      fetch_pc_d   = bus.in_branch_pc + PC_INC;
    end else if (bus.in_flush) begin
      // Refetch from the oldest PC being thrown away.
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      infl_valid_d = 1'b0;
      if (head_valid)        fetch_pc_d = head_pc;
      else if (infl_valid_q) fetch_pc_d = infl_pc_q;
    end else begin
      if (queue_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push)      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d = count_q + (push ? LVL_ONE : '0) - (queue_pop ? LVL_ONE : '0);
      infl_valid_d = issue;
      if (issue) begin
        infl_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_INC;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous, active-low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= PC_RST;
      infl_valid_q <= 1'b0;
      infl_pc_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      infl_valid_q <= infl_valid_d;
      infl_pc_q    <= infl_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // NOTE: queue storage is not reset; count_q gates every read, so stale contents are never seen.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      instr_mem[wr_ptr_q] <= bus.in_instr;
      pc_mem[wr_ptr_q]    <= infl_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model of the fetch stage.
module tb_fetch_prefetch;
  localparam int PC_WIDTH     = 12;
  localparam int PMEM_WIDTH   = 16;
  localparam int PC_INCREMENT = 2;
  localparam int FIFO_DEPTH   = 4;
  localparam int RESET_PC     = 0;
  localparam int LVL_WIDTH    = $clog2(FIFO_DEPTH + 1);
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fetch_prefetch_if #(
    .PC_WIDTH(PC_WIDTH), .PMEM_WIDTH(PMEM_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .LVL_WIDTH(LVL_WIDTH)
  ) bus ();

  fetch_prefetch #(
    .PC_WIDTH(PC_WIDTH), .PMEM_WIDTH(PMEM_WIDTH), .PC_INCREMENT(PC_INCREMENT),
    .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC), .LVL_WIDTH(LVL_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Program memory content: address in the low bits, a tag derived from it on top.
  function automatic logic [PMEM_WIDTH-1:0] word_of(input logic [PC_WIDTH-1:0] a);
    return {~a[3:0], a};
  endfunction

  // Synchronous-read program memory: word for the address seen at the previous edge.
  always @(posedge clock) bus.in_instr <= word_of(bus.out_pmem_addr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: decode-visible queue of PCs, at most one outstanding read, next fetch PC.
  logic [PC_WIDTH-1:0] mq [$];
  logic [PC_WIDTH-1:0] mi [$];
  logic [PC_WIDTH-1:0] mfetch;

  logic                  s_valid;
  logic [PC_WIDTH-1:0]   s_pc, s_addr;
  logic [PMEM_WIDTH-1:0] s_instr;
  logic [LVL_WIDTH-1:0]  s_fill;

  task automatic model_reset();
    mq.delete();
    mi.delete();
    mfetch = PC_WIDTH'(RESET_PC);
  endtask

  // One clock cycle: drive inputs, sample and compare at the falling edge, advance the model.
  task automatic tick(input bit stall, input bit set, input logic [PC_WIDTH-1:0] br, input bit flush);
    logic                  exp_valid;
    logic [PC_WIDTH-1:0]   exp_pc;
    logic [PMEM_WIDTH-1:0] exp_instr;
    bit                    pop, issue;
    bus.in_stall     = stall;
    bus.in_set_pc    = set;
    bus.in_branch_pc = br;
    bus.in_flush     = flush;
    @(negedge clock);
    s_valid = bus.out_valid;
    s_pc    = bus.out_pc;
    s_instr = bus.out_instr;
    s_addr  = bus.out_pmem_addr;
    s_fill  = bus.out_fill_level;

    exp_valid = (mq.size() > 0) || (BYP && mi.size() > 0);
    exp_pc    = (mq.size() > 0) ? mq[0] : (exp_valid ? mi[0] : '0);
    exp_instr = exp_valid ? word_of(exp_pc) : '0;
    check("valid", s_valid, exp_valid);
    check("pc",    s_pc,    exp_pc);
    check("instr", s_instr, exp_instr);
    check("fill",  s_fill,  mq.size());
    check("addr",  s_addr,  set ? br : mfetch);

    pop = exp_valid && !stall;
    if (set) begin
      mq.delete();
      mi.delete();
      mi.push_back(br);
      mfetch = br + PC_WIDTH'(PC_INCREMENT);
    end else if (flush) begin
      if (exp_valid)        mfetch = exp_pc;
      else if (mi.size())   mfetch = mi[0];
      mq.delete();
      mi.delete();
    end else begin
      issue = (mq.size() + mi.size() < FIFO_DEPTH) || pop;
      if (pop && mq.size() > 0) begin
        void'(mq.pop_front());
        if (mi.size()) mq.push_back(mi[0]);
      end else if (!pop && mi.size()) begin
        mq.push_back(mi[0]);
      end
      mi.delete();
      if (issue) begin
        mi.push_back(mfetch);
        mfetch = mfetch + PC_WIDTH'(PC_INCREMENT);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset            = 1'b0;
    bus.in_stall     = 1'b0;
    bus.in_set_pc    = 1'b0;
    bus.in_flush     = 1'b0;
    bus.in_branch_pc = '0;
    #1;
    check("rst_valid", bus.out_valid,      0);
    check("rst_instr", bus.out_instr,      0);
    check("rst_pc",    bus.out_pc,         0);
    check("rst_fill",  bus.out_fill_level, 0);
    check("rst_addr",  bus.out_pmem_addr,  RESET_PC);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Run unstalled until the head is valid, bounded; an expired bound shows up as a failed check.
  task automatic run_until_valid(input int budget);
    for (int i = 0; i < budget && !s_valid; i++) tick(0, 0, '0, 0);
    check("wait_valid", s_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_pct;
    int r;

    // Start-up stream: addresses 0,2,4..., first valid after the fill latency.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, '0, 0);
      check("start_addr", s_addr, 2 * i);
      if (i < LAT) begin
        check("start_idle", s_valid, 0);
      end else begin
        check("start_valid", s_valid, 1);
        check("start_pc", s_pc, 2 * (i - LAT));
      end
    end

    // Stall held: queue saturates, issues stop, head holds.
    apply_reset();
    for (int i = 0; i < 10; i++) tick(1, 0, '0, 0);
    check("stall_fill", s_fill, FIFO_DEPTH);
    check("stall_pc",   s_pc,   0);
    check("stall_addr", s_addr, 8);
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, '0, 0);
      check("drain_valid", s_valid, 1);
      check("drain_pc",    s_pc,    2 * k);
    end

    // Branch redirect with three entries queued.
    apply_reset();
    for (int i = 0; i < 4; i++) tick(1, 0, '0, 0);
    tick(1, 1, 12'h100, 0);
    check("br_fill_before", s_fill, 3);
    check("br_addr",        s_addr, 12'h100);
    tick(0, 0, '0, 0);
    check("br_fill_after",  s_fill, 0);
    run_until_valid(4);
    check("br_pc0", s_pc, 12'h100);
    tick(0, 0, '0, 0);
    check("br_pc1", s_pc, 12'h102);

    // Replay flush with head 0x010 and three entries queued.
    apply_reset();
    tick(1, 1, 12'h010, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, '0, 0);
    tick(1, 0, '0, 1);
    check("fl_fill_before", s_fill, 3);
    check("fl_head",        s_pc,   12'h010);
    tick(0, 0, '0, 0);
    check("fl_fill_after",  s_fill,  0);
    check("fl_no_valid",    s_valid, 0);
    check("fl_refetch",     s_addr,  12'h010);
    run_until_valid(4);
    check("fl_pc0", s_pc, 12'h010);
    tick(0, 0, '0, 0);
    check("fl_pc1", s_pc, 12'h012);

    // PC wrap at the top of the address space.
    apply_reset();
    tick(0, 1, 12'hFFE, 0);
    check("wrap_addr0", s_addr, 12'hFFE);
    tick(0, 0, '0, 0);
    check("wrap_addr1", s_addr, 12'h000);
    run_until_valid(4);
    check("wrap_pc0", s_pc, 12'hFFE);
    tick(0, 0, '0, 0);
    check("wrap_pc1", s_pc, 12'h000);

    // Reset mid-stream: two entries queued and a read in flight.
    apply_reset();
    for (int i = 0; i < 3; i++) tick(1, 0, '0, 0);
    apply_reset();
    tick(0, 0, '0, 0);
    run_until_valid(4);
    check("mid_rst_pc", s_pc, RESET_PC);

    // Randomized traffic with varying stall pressure, redirects, flushes and rare resets.
    apply_reset();
    stall_pct = 30;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) stall_pct = $urandom_range(0, 90);
      if ($urandom_range(0, 599) == 0) apply_reset();
      r = $urandom_range(0, 99);
      tick($urandom_range(0, 99) < stall_pct, r < 6,
           ($urandom_range(0, 3) == 0) ? 12'hFFA : (PC_WIDTH'($urandom) & 12'hFFE),
           (r >= 4) && (r < 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised successor of the single-register fetch stage.
- Decouples program-memory fetch from decode using a FIFO_DEPTH-entry instruction/PC queue plus one in-flight PMEM request.
- Sits between pmem_sim (synchronous read, word returned one cycle after address) and the decoder.
- Supports zero-bubble branch redirect and a replay flush.

Parameters:
- PC_WIDTH, 12: PC and PMEM address width.
- PMEM_WIDTH, 16: instruction word width.
- PC_INCREMENT, 2: PC step per fetched word.
- FIFO_DEPTH, 4: queue entries; power of two, minimum 2.
- RESET_PC, 0: first fetch address after reset.
- LVL_WIDTH, $clog2(FIFO_DEPTH+1): fill-level width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_branch_pc  in  PC_WIDTH  redirect target.
- in_set_pc  in  1  redirect request; implies flush.
- in_flush  in  1  replay flush (discard queue, refetch oldest discarded PC).
- in_stall  in  1  decoder not accepting this cycle.
- in_instr  in  PMEM_WIDTH  PMEM read word (for address issued previous cycle).
- out_pmem_addr  out  PC_WIDTH  PMEM read address (combinational).
- out_instr  out  PMEM_WIDTH  head instruction; 0x0000 when not valid.
- out_pc  out  PC_WIDTH  head PC; 0 when not valid.
- out_valid  out  1  head entry valid.
- out_fill_level  out  LVL_WIDTH  queue occupancy.

Behaviour:
- Reset (reset=0, async):
  - queue empty, in-flight invalid, fetch_pc=RESET_PC;
  - out_valid=0, out_instr=0, out_pc=0, out_fill_level=0, out_pmem_addr=RESET_PC.
- State:
  - fetch_pc;
  - in-flight {valid, pc};
  - circular queue with rd/wr pointers and count, pointers wrapping modulo FIFO_DEPTH.
- Pop: head removed at clock edge when out_valid=1 and in_stall=0.
- Issue condition: issue when count + inflight_valid < FIFO_DEPTH, or when a pop occurs this cycle, and in_flush=0.
  - On issue: in-flight <= {1, fetch_pc}, fetch_pc <= fetch_pc + PC_INCREMENT.
  - PC arithmetic wraps modulo 2^PC_WIDTH.
- out_pmem_addr = in_set_pc ? in_branch_pc : fetch_pc, whether or not an issue occurs.
- Arrival: when in-flight valid, in_instr is pushed with the in-flight pc at the next edge.
  - Push and pop in the same cycle leave count unchanged; full+push can never occur by the issue rule.
- Baseline latency: address issued in cycle t; out_valid rises in cycle t+2.
- in_set_pc=1 (priority over in_flush):
  - queue cleared, arriving word discarded, count=0;
  - in_branch_pc issued this cycle; in-flight <= {1, in_branch_pc}, fetch_pc <= in_branch_pc + PC_INCREMENT;
  - in_stall ignored for this cycle.
  - First redirected instruction is valid 2 cycles later, or 1 cycle later with the optional feature.
- in_flush=1, in_set_pc=0:
  - queue and in-flight discarded; no issue this cycle;
  - fetch_pc <= oldest discarded PC, in priority order: head pc, else in-flight pc, else fetch_pc unchanged.
- Stall held with queue full: no issue, no PMEM activity; outputs held stable.
- Reset asserted mid-operation: immediate return to reset state; any in-flight word is dropped.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - when the queue is empty and an in-flight word arrives, it is presented combinationally that cycle (out_valid=1, out_instr=in_instr, out_pc=in-flight pc);
  - if popped that cycle it is not written to the queue;
  - latency becomes t+1.
- Undefined: arriving words always go through the queue; latency t+2; all outputs are registered/queue-derived.

Test Plan:
- Reset release, PMEM word = address value, no stall:
  - out_pmem_addr sequence 0,2,4,6…;
  - out_valid first high cycle 2 (cycle 1 with FETCH_BYPASS_EN), out_pc=0;
  - thereafter one instruction per cycle, pc 2,4,…
- Stall held 10 cycles after start (FIFO_DEPTH=4):
  - out_fill_level saturates at 4, issues stop, out_pc holds 0x000;
  - on release, pc 0,2,4,6,8 emitted consecutively with no gaps.
- in_set_pc with in_branch_pc=0x100 while queue holds 3 entries:
  - same-cycle out_pmem_addr=0x100;
  - fill level 0 next cycle;
  - next valid out_pc=0x100, then 0x102; no stale PCs emitted.
- in_flush alone with head pc=0x010, queue 3 entries:
  - fill level 0, no issue in the flush cycle;
  - next issued address 0x010; output resumes 0x010, 0x012.
- fetch_pc=0xFFE (PC_WIDTH=12), no stall: addresses 0xFFE then 0x000; out_pc follows 0xFFE, 0x000.
- Assert reset mid-stream with 2 entries queued and in-flight valid:
  - all outputs immediately at reset values;
  - after release, first out_pc=RESET_PC.
